pwm_ramp_sequencer: RTL and testbench
=====================================

# pwm_ramp_sequencer

Bus-master controller that drives the PWM peripheral's CTRL register to ramp duty from a start value to a target value, giving soft-start and fade. Each step is written to CTRL, then held for a programmable number of PWM periods. Optionally, STATUS is read back after each write. The block sits between system control logic and the PWM peripheral's addr/wdata/wen/ren/rdata slave port.

## Interface
- CTRL_ADDR, 8'h00, CTRL register address ({period[31:16], duty[15:0]})
- STATUS_ADDR, 8'h04, STATUS register address (bit0 = error_flag)
- HOLD_W, 8, width of hold_periods
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches the configuration and begins a ramp
- abort  in  1  cancels the ramp; takes priority over start
- period  in  16  PWM period in clk cycles
- duty_start  in  16  first duty written
- duty_target  in  16  final duty
- duty_step  in  16  duty increment magnitude; 0 = jump straight to target
- hold_periods  in  HOLD_W  PWM periods per step; 0 is treated as 1
- m_addr  out  8  bus address
- m_wdata  out  32  bus write data
- m_wen  out  1  write strobe, one cycle
- m_ren  out  1  read strobe, one cycle
- m_rdata  in  32  read data, valid the cycle after m_ren
- busy  out  1  ramp in progress
- done  out  1  level; set when target is reached, cleared by the next accepted start
- error  out  1  level; set on config or status error, cleared by the next accepted start
- cur_duty  out  16  last duty written to CTRL

## Operation
- States: IDLE, WRITE, CHK_RD, CHK_WAIT, DWELL, DONE, ERROR.
- IDLE:
  - On start, latch all config inputs.
  - If period==0, duty_start>period or duty_target>period, go to ERROR with no bus cycle. Otherwise go to WRITE with duty=duty_start.
- WRITE: one cycle with m_addr=CTRL_ADDR, m_wdata={period,duty}, m_wen=1. Update cur_duty.
- CHK_RD: one cycle with m_addr=STATUS_ADDR, m_ren=1.
- CHK_WAIT: sample m_rdata[0]. If 1, go to ERROR.
- After the check (or directly after WRITE when the check is compiled out):
  - If duty==duty_target, go to DONE.
  - Otherwise go to DWELL.
- DWELL:
  - Lasts exactly max(hold,1)*period cycles.
  - On exit, compute the next duty:
    - Up ramp (target>duty): next = min(duty+step, target).
    - Down ramp: next = max(duty-step, target).
    - Compute in 17 bits; never overshoot, never wrap.
    - step==0: next = target.
  - Then go to WRITE.
- DONE / ERROR: set done or error, drop busy, return to IDLE the next cycle. Flags hold until the next accepted start.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Next state is IDLE; m_wen and m_ren deassert the next cycle.
  - No further bus cycles; done and error stay 0; cur_duty is retained.
- Simultaneous start and abort in IDLE: abort wins, start is ignored.

## Timing
- Reset values:
  - All outputs 0, including m_addr and m_wdata.
  - State IDLE; all counters 0.
- start sampled at edge N: busy=1 and the first m_wen in cycle N+1.
- Spacing between consecutive writes:
  - max(hold,1)*period + 3 cycles with the status check.
  - max(hold,1)*period + 1 cycles without it.
- Last write or check to done=1: 1 cycle. A config error raises error in cycle N+1.
- Bus strobes are never asserted together; address and data are held stable only during the strobe cycle.
- Reset mid-operation: a synchronous return to reset values; any in-flight strobe drops at that edge.

## Configuration
- PWM_SEQ_STATUS_CHECK_EN defined:
  - CHK_RD and CHK_WAIT are present; STATUS bit0 aborts the ramp into ERROR.
- Not defined:
  - Both states are removed; m_ren is tied to 0 and m_rdata is ignored.
  - error is raised only by the config check.
  - Write spacing drops to hold*period+1.

## Structure
- Package pwm_seq_pkg holds:
  - The state enum.
  - Default CTRL_ADDR and STATUS_ADDR.
  - Duty and period widths (16).
  - The CTRL field-packing positions (period [31:16], duty [15:0]).
- Sub-module pwm_seq_dwell_timer:
  - Nested counters: cycle count 0..period-1 and period count 0..hold-1.
  - Inputs: load and the latched period/hold. Output: a one-cycle expire pulse.
  - The top FSM instantiates one of it.

## Test plan
- Up ramp, macro on (period=100, start=10, target=40, step=10, hold=2):
  - Writes 0x0064000A, 0x00640014, 0x0064001E, 0x00640028, each 203 cycles apart.
  - done=1, cur_duty=40, busy=0.
- Down ramp with saturation (period=100, start=50, target=5, step=20, hold=1):
  - Writes duties 50, 30, 10, 5; no value below 5; done=1.
- Config error (period=50, target=60):
  - error=1 in cycle N+1; m_wen never asserted; done=0.
- Status error, macro on: a slave stub returns STATUS=0x1 after the first write.
  - Exactly one m_wen and one m_ren; error=1; no DWELL.
- Abort and busy rules:
  - Abort during the first DWELL: busy=0 next cycle, no further strobes, cur_duty=start value.
  - A start pulse issued while busy is ignored.
- Edge configs (step=0, hold=0, period=10, start=2, target=8):
  - Writes duty 2, then duty 8 after 13 cycles; done=1.
  - With the macro off, the spacing is 11 cycles.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared encodings, CTRL field layout and duty-step arithmetic for the PWM ramp sequencer.
// Pure definitions: no state, no latency, no flow control.
package pwm_seq_pkg;

  localparam int DUTY_W   = 16;
  localparam int PERIOD_W = 16;

  localparam logic [7:0] CTRL_ADDR_DEF   = 8'h00;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'h04;

  localparam int CTRL_DUTY_LSB   = 0;
  localparam int CTRL_PERIOD_LSB = 16;

  // State encoding kept as plain constants so older tools and netlists see a bare vector.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WRITE    = 3'd1;
  localparam state_t ST_CHK_RD   = 3'd2;
  localparam state_t ST_CHK_WAIT = 3'd3;
  localparam state_t ST_DWELL    = 3'd4;
  localparam state_t ST_DONE     = 3'd5;
  localparam state_t ST_ERROR    = 3'd6;

  function automatic logic [31:0] pack_ctrl(input logic [PERIOD_W-1:0] period,
                                            input logic [DUTY_W-1:0]   duty);
    logic [31:0] r;
    r = '0;
    r[CTRL_PERIOD_LSB +: PERIOD_W] = period;
    r[CTRL_DUTY_LSB   +: DUTY_W]   = duty;
    return r;
  endfunction

  // 17-bit arithmetic so neither direction can wrap past the target.
  function automatic logic [DUTY_W-1:0] next_duty(input logic [DUTY_W-1:0] duty,
                                                  input logic [DUTY_W-1:0] target,
                                                  input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   diff;
    logic [DUTY_W-1:0] r;
    sum  = {1'b0, duty} + {1'b0, step};
    diff = {1'b0, duty} - {1'b0, step};
    if (step == '0)
      r = target;
    else if (target > duty)
      r = (sum > {1'b0, target}) ? target : sum[DUTY_W-1:0];
    else
      r = (diff[DUTY_W] || (diff[DUTY_W-1:0] < target)) ? target : diff[DUTY_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pwm_seq_dwell_timer.sv
// Dwell timer: after load, counts period cycles x max(hold,1) periods and pulses expire on the last cycle.
// No flow control; clr cancels a running dwell immediately.
module pwm_seq_dwell_timer
  import pwm_seq_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  input  logic [HOLD_W-1:0]   hold,
  output logic                expire
);

  logic                active;
  logic [PERIOD_W-1:0] cyc_cnt;
  logic [HOLD_W-1:0]   per_cnt;
  logic [HOLD_W-1:0]   hold_eff;
  logic                last_cyc;
  logic                last_per;

  assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
  assign last_cyc = (cyc_cnt == period - PERIOD_W'(1));
  assign last_per = (per_cnt == hold_eff - HOLD_W'(1));
  assign expire   = active && last_cyc && last_per;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      active  <= 1'b0;
      cyc_cnt <= '0;
      per_cnt <= '0;
    end else if (load) begin
      active  <= 1'b1;
      cyc_cnt <= '0;
      per_cnt <= '0;
    end else if (active) begin
      if (last_cyc) begin
        cyc_cnt <= '0;
        if (last_per) begin
          per_cnt <= '0;
          active  <= 1'b0;
        end else begin
          per_cnt <= per_cnt + HOLD_W'(1);
        end
      end else begin
        cyc_cnt <= cyc_cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Bus master ramping the PWM CTRL duty from start to target, one write per dwell; first write 1 cycle after start.
// PWM_SEQ_STATUS_CHECK_EN adds a STATUS read-back after each write; abort returns to IDLE at the next edge.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter logic [7:0] CTRL_ADDR   = CTRL_ADDR_DEF,
  parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter int         HOLD_W      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty_start,
  input  logic [DUTY_W-1:0]   duty_target,
  input  logic [DUTY_W-1:0]   duty_step,
  input  logic [HOLD_W-1:0]   hold_periods,
  output logic [7:0]          m_addr,
  output logic [31:0]         m_wdata,
  output logic                m_wen,
  output logic                m_ren,
  input  logic [31:0]         m_rdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DUTY_W-1:0]   cur_duty
);

  state_t              state;
  state_t              state_nxt;
  logic [PERIOD_W-1:0] period_q;
  logic [DUTY_W-1:0]   target_q;
  logic [DUTY_W-1:0]   step_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [DUTY_W-1:0]   duty_q;
  logic [DUTY_W-1:0]   cur_duty_q;
  logic                done_q;
  logic                error_q;
  logic                accept;
  logic                cfg_bad;
  logic                at_target;
  logic                dwell_load;
  logic                dwell_expire;
  logic                unused_rdata;

  assign accept    = (state == ST_IDLE) && start && !abort;
  assign cfg_bad   = (period == '0) || (duty_start > period) || (duty_target > period);
  assign at_target = (duty_q == target_q);

`ifdef PWM_SEQ_STATUS_CHECK_EN
  assign unused_rdata = ^m_rdata[31:1];
`else
  assign unused_rdata = ^m_rdata;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = cfg_bad ? ST_ERROR : ST_WRITE;
`ifdef PWM_SEQ_STATUS_CHECK_EN
      ST_WRITE:    state_nxt = ST_CHK_RD;
      ST_CHK_RD:   state_nxt = ST_CHK_WAIT;
      ST_CHK_WAIT: begin
        if (m_rdata[0])     state_nxt = ST_ERROR;
        else if (at_target) state_nxt = ST_DONE;
        else                state_nxt = ST_DWELL;
      end
`else
      ST_WRITE:    state_nxt = at_target ? ST_DONE : ST_DWELL;
`endif
      ST_DWELL:    if (dwell_expire) state_nxt = ST_WRITE;
      ST_DONE:     state_nxt = ST_IDLE;
      ST_ERROR:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  assign dwell_load = (state_nxt == ST_DWELL) && (state != ST_DWELL);

  pwm_seq_dwell_timer #(
    .HOLD_W (HOLD_W)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (abort),
    .load    (dwell_load),
    .period  (period_q),
    .hold    (hold_q),
    .expire  (dwell_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      period_q   <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      duty_q     <= '0;
      cur_duty_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        period_q <= period;
        target_q <= duty_target;
        step_q   <= duty_step;
        hold_q   <= hold_periods;
        duty_q   <= duty_start;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end
      // The strobe has already reached the slave, so even an aborted write is reflected.
      if (state == ST_WRITE) cur_duty_q <= duty_q;
      if ((state == ST_DWELL) && dwell_expire) duty_q <= next_duty(duty_q, target_q, step_q);
      if ((state_nxt == ST_DONE) && (state != ST_DONE))   done_q  <= 1'b1;
      if ((state_nxt == ST_ERROR) && (state != ST_ERROR)) error_q <= 1'b1;
    end
  end

  // Address and data are only driven during their strobe cycle.
  always_comb begin
    m_addr  = 8'h00;
    m_wdata = 32'h0;
    m_wen   = 1'b0;
    m_ren   = 1'b0;
    if (state == ST_WRITE) begin
      m_addr  = CTRL_ADDR;
      m_wdata = pack_ctrl(period_q, duty_q);
      m_wen   = 1'b1;
    end
`ifdef PWM_SEQ_STATUS_CHECK_EN
    else if (state == ST_CHK_RD) begin
      m_addr = STATUS_ADDR;
      m_ren  = 1'b1;
    end
`endif
  end

  assign busy     = (state == ST_WRITE) || (state == ST_CHK_RD) ||
                    (state == ST_CHK_WAIT) || (state == ST_DWELL);
  assign done     = done_q;
  assign error    = error_q;
  assign cur_duty = cur_duty_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: expected CTRL writes (data and cycle) are queued at launch,
// a negedge monitor pops and compares them as the DUT strobes the bus.
module tb_pwm_ramp_sequencer;
  import pwm_seq_pkg::*;

`ifdef PWM_SEQ_STATUS_CHECK_EN
  localparam int CHK_EXTRA = 3;
`else
  localparam int CHK_EXTRA = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] period;
  logic [15:0] duty_start;
  logic [15:0] duty_target;
  logic [15:0] duty_step;
  logic [7:0]  hold_periods;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_wen;
  logic        m_ren;
  logic [31:0] m_rdata = 32'h0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] cur_duty;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] status_val = 32'h0;

  pwm_ramp_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .period       (period),
    .duty_start   (duty_start),
    .duty_target  (duty_target),
    .duty_step    (duty_step),
    .hold_periods (hold_periods),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wen        (m_wen),
    .m_ren        (m_ren),
    .m_rdata      (m_rdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cur_duty     (cur_duty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Slave stub: STATUS returned the cycle after the read strobe.
  always @(posedge clk) m_rdata <= m_ren ? status_val : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_wen || m_ren) chk("strobe_exclusive", {31'h0, m_wen & m_ren}, 32'h0);
    if (m_wen) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got 0x%08h expected none (cycle %0d)", m_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_data", m_wdata, e.dat);
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", {24'h0, m_addr}, 32'h00000000);
      end
    end
    if (m_ren) begin
      rd_count++;
      chk("rd_addr", {24'h0, m_addr}, 32'h00000004);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] p, input logic [15:0] s, input logic [15:0] t,
                        input logic [15:0] st, input logic [7:0] h, output int base);
    tick();
    period = p; duty_start = s; duty_target = t; duty_step = st; hold_periods = h;
    start = 1'b1;
    base = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_wr(input int c, input logic [15:0] p, input logic [15:0] d);
    wr_t e;
    e.dat = {p, d};
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_end(input string name, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (done || error) hit = 1'b1;
      else tick();
    end
    chk(name, {31'h0, hit}, 32'h1);
  endtask

  initial begin
    int base;
    int sp;
    int w0;
    int r0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    period = '0; duty_start = '0; duty_target = '0; duty_step = '0; hold_periods = '0;
    repeat (3) tick();
    chk("rst_outputs", {m_addr, m_wen, m_ren, busy, done, error, 4'h0, cur_duty}, 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    reset_n = 1'b1;
    tick();

    // Up ramp 10 -> 40 by 10, hold 2.
    sp = 200 + CHK_EXTRA;
    launch(16'd100, 16'd10, 16'd40, 16'd10, 8'd2, base);
    chk("up_busy_n1", {31'h0, busy}, 32'h1);
    expect_wr(base + 1,          16'd100, 16'd10);
    expect_wr(base + 1 + sp,     16'd100, 16'd20);
    expect_wr(base + 1 + 2 * sp, 16'd100, 16'd30);
    expect_wr(base + 1 + 3 * sp, 16'd100, 16'd40);
    r0 = rd_count;
    wait_end("up_end", 1000);
    chk("up_done_cycle", cyc, base + 1 + 3 * sp + CHK_EXTRA);
    chk("up_flags", {29'h0, done, error, busy}, 32'h4);
    chk("up_cur_duty", {16'h0, cur_duty}, 32'd40);
    chk("up_q_empty", exp_q.size(), 32'h0);
`ifdef PWM_SEQ_STATUS_CHECK_EN
    chk("up_reads", rd_count - r0, 32'd4);
`else
    chk("up_reads", rd_count - r0, 32'd0);
`endif

    // Down ramp 50 -> 5 by 20: saturates at 5.
    sp = 100 + CHK_EXTRA;
    launch(16'd100, 16'd50, 16'd5, 16'd20, 8'd1, base);
    chk("dn_flags_cleared", {30'h0, done, busy}, 32'h1);
    expect_wr(base + 1,          16'd100, 16'd50);
    expect_wr(base + 1 + sp,     16'd100, 16'd30);
    expect_wr(base + 1 + 2 * sp, 16'd100, 16'd10);
    expect_wr(base + 1 + 3 * sp, 16'd100, 16'd5);
    wait_end("dn_end", 600);
    chk("dn_flags", {29'h0, done, error, busy}, 32'h4);
    chk("dn_cur_duty", {16'h0, cur_duty}, 32'd5);
    chk("dn_q_empty", exp_q.size(), 32'h0);

    // Config error: target above period.
    w0 = wr_count;
    launch(16'd50, 16'd10, 16'd60, 16'd5, 8'd1, base);
    chk("cfg_flags_n1", {29'h0, done, error, busy}, 32'h2);
    repeat (10) tick();
    chk("cfg_flags_hold", {29'h0, done, error, busy}, 32'h2);
    chk("cfg_no_write", wr_count - w0, 32'h0);

`ifdef PWM_SEQ_STATUS_CHECK_EN
    // STATUS error after the first write.
    status_val = 32'h1;
    w0 = wr_count;
    r0 = rd_count;
    launch(16'd100, 16'd10, 16'd40, 16'd10, 8'd2, base);
    expect_wr(base + 1, 16'd100, 16'd10);
    wait_end("st_end", 50);
    chk("st_err_cycle", cyc, base + 4);
    chk("st_flags", {29'h0, done, error, busy}, 32'h2);
    repeat (20) tick();
    chk("st_writes", wr_count - w0, 32'd1);
    chk("st_reads", rd_count - r0, 32'd1);
    status_val = 32'h0;
`endif

    // Abort in first dwell; a start issued while busy is ignored.
    w0 = wr_count;
    launch(16'd10, 16'd2, 16'd8, 16'd2, 8'd1, base);
    expect_wr(base + 1, 16'd10, 16'd2);
    repeat (3) tick();
    duty_start = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_busy_before", {31'h0, busy}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_flags_next", {28'h0, done, error, busy, m_wen}, 32'h0);
    chk("ab_cur_duty", {16'h0, cur_duty}, 32'd2);
    repeat (40) tick();
    chk("ab_idle_later", {29'h0, done, error, busy}, 32'h0);
    chk("ab_writes", wr_count - w0, 32'd1);

    // Simultaneous start and abort in IDLE: abort wins.
    w0 = wr_count;
    tick();
    period = 16'd10; duty_start = 16'd2; duty_target = 16'd8; duty_step = 16'd1; hold_periods = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", {31'h0, busy}, 32'h0);
    repeat (20) tick();
    chk("sa_writes", wr_count - w0, 32'd0);

    // Edge config: step 0 jumps to target, hold 0 acts as 1.
    launch(16'd10, 16'd2, 16'd8, 16'd0, 8'd0, base);
    expect_wr(base + 1,                  16'd10, 16'd2);
    expect_wr(base + 1 + 10 + CHK_EXTRA, 16'd10, 16'd8);
    wait_end("edge_end", 100);
    chk("edge_flags", {29'h0, done, error, busy}, 32'h4);
    chk("edge_cur_duty", {16'h0, cur_duty}, 32'd8);
    chk("edge_q_empty", exp_q.size(), 32'h0);

    // Reset in the middle of a dwell.
    w0 = wr_count;
    launch(16'd100, 16'd10, 16'd40, 16'd10, 8'd1, base);
    expect_wr(base + 1, 16'd100, 16'd10);
    repeat (6) tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_outputs", {m_addr, m_wen, m_ren, busy, done, error, 4'h0, cur_duty}, 32'h0);
    reset_n = 1'b1;
    repeat (250) tick();
    chk("mid_rst_writes", wr_count - w0, 32'd1);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
